// File: rtl/breakout_ctrl_pkg.sv
// Shared types and helpers for the Breakout paddle position encoder.
package breakout_ctrl_pkg;

    localparam int unsigned POS_W      = 8;
    localparam int unsigned POS_INIT   = 114;
    localparam int unsigned DELTA_SLOW = 4;
    localparam int unsigned DELTA_FAST = 8;

    // Non-INV modes invert the raw source so "right" moves toward position 0,
    // matching the digital buttons.
    typedef enum logic [2:0] {
        PM_DIGITAL    = 3'd0,
        PM_X          = 3'd1,
        PM_X_INV      = 3'd2,
        PM_Y          = 3'd3,
        PM_Y_INV      = 3'd4,
        PM_PADDLE     = 3'd5,
        PM_PADDLE_INV = 3'd6,
        PM_PARK       = 3'd7
    } pad_mode_t;

    // Signed two's-complement axis to offset binary (-128 -> 0, +127 -> 255).
    function automatic logic [POS_W-1:0] to_offset_bin(input logic [POS_W-1:0] a);
        return {~a[POS_W-1], a[POS_W-2:0]};
    endfunction

endpackage

// File: rtl/breakout_paddle_ctrl_digital_acc.sv
// One 8-bit saturating position accumulator stepped by inc/dec when enabled.
module paddle_digital_acc
    import breakout_ctrl_pkg::*;
#(
    parameter int unsigned INIT = POS_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic [POS_W-1:0] delta,
    output logic [POS_W-1:0] pos
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W:0]   sum;

    // Nine-bit sum exposes overflow so the top end clamps instead of wrapping.
    always_comb begin
        sum   = {1'b0, pos_q} + {1'b0, delta};
        pos_d = pos_q;
        if (en && inc && !dec) begin
            pos_d = sum[POS_W] ? '1 : sum[POS_W-1:0];
        end else if (en && dec && !inc) begin
            pos_d = (pos_q < delta) ? '0 : pos_q - delta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos_q <= POS_W'(INIT);
        else        pos_q <= pos_d;
    end

    assign pos = pos_q;

endmodule

// File: rtl/breakout_paddle_ctrl.sv
// Paddle position encoder: selects a per-player target, latches it outside the
// measurement window and drives the core's "line count < position" PAD_OUT.
module breakout_paddle_ctrl
    import breakout_ctrl_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             pad_en_n,
    input  logic             player2,
    input  logic             speed,
    input  logic [2:0]       p1_mode,
    input  logic [2:0]       p2_mode,
    input  logic             p1_left,
    input  logic             p1_right,
    input  logic             p2_left,
    input  logic             p2_right,
    input  logic [POS_W-1:0] p1_ax,
    input  logic [POS_W-1:0] p1_ay,
    input  logic [POS_W-1:0] p2_ax,
    input  logic [POS_W-1:0] p2_ay,
    input  logic [POS_W-1:0] paddle_0,
    input  logic [POS_W-1:0] paddle_1,
    output logic             pad_out,
    output logic [POS_W-1:0] pos_active
);

    logic             hsync_q, vsync_q;
    logic             hs_rise, vs_rise;
    logic [POS_W-1:0] delta;
    logic [POS_W-1:0] dpos1, dpos2;
    logic [POS_W-1:0] target1, target2, target_sel;
    logic [POS_W-1:0] pos_lat_q, pos_lat_d;
    logic [POS_W-1:0] cnt_q, cnt_d;
    logic             pad_out_q, pad_out_d;

    function automatic logic [POS_W-1:0] mode_target(
        input pad_mode_t        m,
        input logic [POS_W-1:0] dpos,
        input logic [POS_W-1:0] ax,
        input logic [POS_W-1:0] ay,
        input logic [POS_W-1:0] pad
    );
        logic [POS_W-1:0] t;
        t = POS_W'(POS_INIT);
        case (m)
            PM_DIGITAL:    t = dpos;
            PM_X:          t = ~to_offset_bin(ax);
            PM_X_INV:      t = to_offset_bin(ax);
            PM_Y:          t = ~to_offset_bin(ay);
            PM_Y_INV:      t = to_offset_bin(ay);
            PM_PADDLE:     t = ~pad;
            PM_PADDLE_INV: t = pad;
            PM_PARK:       t = POS_W'(POS_INIT);
            default:       t = POS_W'(POS_INIT);
        endcase
        return t;
    endfunction

    assign hs_rise = hsync & ~hsync_q;
    assign vs_rise = vsync & ~vsync_q;
    assign delta   = speed ? POS_W'(DELTA_FAST) : POS_W'(DELTA_SLOW);

    paddle_digital_acc #(.INIT(POS_INIT)) u_acc1 (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .en    (vs_rise & ~player2),
        .inc   (p1_left),
        .dec   (p1_right),
        .delta (delta),
        .pos   (dpos1)
    );

    paddle_digital_acc #(.INIT(POS_INIT)) u_acc2 (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .en    (vs_rise & player2),
        .inc   (p2_left),
        .dec   (p2_right),
        .delta (delta),
        .pos   (dpos2)
    );

    // Target is tracked only while the window is armed, so the core sees one value per window.
    always_comb begin
        target1    = mode_target(pad_mode_t'(p1_mode), dpos1, p1_ax, p1_ay, paddle_0);
        target2    = mode_target(pad_mode_t'(p2_mode), dpos2, p2_ax, p2_ay, paddle_1);
        target_sel = player2 ? target2 : target1;
        pos_lat_d  = pad_en_n ? pos_lat_q : target_sel;
        cnt_d      = cnt_q;
        if (!pad_en_n) begin
            cnt_d = '0;
        end else if (hs_rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + POS_W'(1);
        end
        pad_out_d  = (cnt_q < pos_lat_q);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            pos_lat_q <= POS_W'(POS_INIT);
            cnt_q     <= '0;
            pad_out_q <= 1'b0;
        end else begin
            hsync_q   <= hsync;
            vsync_q   <= vsync;
            pos_lat_q <= pos_lat_d;
            cnt_q     <= cnt_d;
            pad_out_q <= pad_out_d;
        end
    end

    assign pad_out    = pad_out_q;
    assign pos_active = pos_lat_q;

endmodule

// File: tb/tb_breakout_paddle_ctrl.sv
// Self-checking bench for breakout_paddle_ctrl: mode vector table plus window/reset sequences.
module tb_breakout_paddle_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset_n, hsync, vsync, pad_en_n, player2, speed;
    logic [2:0] p1_mode, p2_mode;
    logic       p1_left, p1_right, p2_left, p2_right;
    logic [7:0] p1_ax, p1_ay, p2_ax, p2_ay, paddle_0, paddle_1;
    logic       pad_out;
    logic [7:0] pos_active;

    breakout_paddle_ctrl dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .pad_en_n   (pad_en_n),
        .player2    (player2),
        .speed      (speed),
        .p1_mode    (p1_mode),
        .p2_mode    (p2_mode),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .p1_ax      (p1_ax),
        .p1_ay      (p1_ay),
        .p2_ax      (p2_ax),
        .p2_ay      (p2_ay),
        .paddle_0   (paddle_0),
        .paddle_1   (paddle_1),
        .pad_out    (pad_out),
        .pos_active (pos_active)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string      name;
        logic [7:0] exp;
        bit         is_pad;
    } sb_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] ax;
        logic [7:0] ay;
        logic [7:0] pad;
        logic [7:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_dpos1 = 114;
    int   m_dpos2 = 114;
    int   m_cnt = 0;

    function automatic int acc_step(input int p, input bit l, input bit r, input bit spd);
        int d;
        int v;
        d = spd ? 8 : 4;
        v = p;
        if (l && !r)      v = (v + d > 255) ? 255 : v + d;
        else if (r && !l) v = (v < d) ? 0 : v - d;
        return v;
    endfunction

    task automatic push_pos(input string name, input int exp);
        sb_t e;
        e.name = name; e.exp = 8'(exp); e.is_pad = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_pad(input string name, input bit exp);
        sb_t e;
        e.name = name; e.exp = {7'd0, exp}; e.is_pad = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic compare_all();
        sb_t        e;
        logic [7:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = e.is_pad ? {7'd0, pad_out} : pos_active;
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic frame(input bit l1, input bit r1, input bit l2, input bit r2);
        p1_left = l1; p1_right = r1; p2_left = l2; p2_right = r2;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        p1_left = 0; p1_right = 0; p2_left = 0; p2_right = 0;
        tick();
        if (!player2) m_dpos1 = acc_step(m_dpos1, l1, r1, speed);
        else          m_dpos2 = acc_step(m_dpos2, l2, r2, speed);
    endtask

    task automatic latch_window(input string name, input int exp);
        pad_en_n = 1'b0;
        tick();
        tick();
        pad_en_n = 1'b1;
        m_cnt = 0;
        push_pos({name, " pos"}, exp);
        push_pad({name, " pad"}, exp != 0);
        @(negedge clk_sys);
        compare_all();
        tick();
    endtask

    task automatic hpulse(input string name, input int lat);
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        push_pad($sformatf("%s lag cnt%0d", name, m_cnt), m_cnt < lat);
        @(negedge clk_sys);
        compare_all();
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        tick();
        push_pad($sformatf("%s cnt%0d", name, m_cnt), m_cnt < lat);
        @(negedge clk_sys);
        compare_all();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd1, 8'h00, 8'h00, 8'h00, 8'h7F};
        vecs[1] = '{3'd2, 8'h00, 8'h00, 8'h00, 8'h80};
        vecs[2] = '{3'd1, 8'h7F, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{3'd2, 8'h80, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{3'd2, 8'h7F, 8'h00, 8'h00, 8'hFF};
        vecs[5] = '{3'd3, 8'h00, 8'h10, 8'h00, 8'h6F};
        vecs[6] = '{3'd4, 8'h00, 8'hF0, 8'h00, 8'h70};
        vecs[7] = '{3'd5, 8'h00, 8'h00, 8'h20, 8'hDF};
        vecs[8] = '{3'd6, 8'h00, 8'h00, 8'h20, 8'h20};
        vecs[9] = '{3'd7, 8'h55, 8'hAA, 8'h33, 8'h72};

        reset_n = 0; hsync = 0; vsync = 0; pad_en_n = 1; player2 = 0; speed = 0;
        p1_mode = 0; p2_mode = 0;
        p1_left = 0; p1_right = 0; p2_left = 0; p2_right = 0;
        p1_ax = 0; p1_ay = 0; p2_ax = 0; p2_ay = 0; paddle_0 = 0; paddle_1 = 0;
        repeat (3) @(posedge clk_sys);
        push_pos("reset pos", 114);
        push_pad("reset pad", 1'b0);
        @(negedge clk_sys);
        compare_all();
        tick();
        reset_n = 1;
        tick();

        // Fast right steps down to 2, then clamp at 0
        speed = 1;
        repeat (14) frame(0, 1, 0, 0);
        latch_window("dig to2", m_dpos1);
        frame(0, 1, 0, 0);
        latch_window("dig clamp0", m_dpos1);
        frame(0, 1, 0, 0);
        latch_window("dig hold0", m_dpos1);

        reset_n = 0;
        tick();
        reset_n = 1;
        m_dpos1 = 114; m_dpos2 = 114;
        tick();

        speed = 0;
        repeat (3) frame(0, 1, 0, 0);
        latch_window("dig slow3", m_dpos1);
        frame(1, 1, 0, 0);
        latch_window("dig both", m_dpos1);
        speed = 1;
        repeat (20) frame(1, 0, 0, 0);
        latch_window("dig sat255", m_dpos1);
        frame(1, 0, 0, 0);
        latch_window("dig hold255", m_dpos1);

        for (int i = 0; i < 10; i++) begin
            p1_mode = vecs[i].mode; p1_ax = vecs[i].ax; p1_ay = vecs[i].ay; paddle_0 = vecs[i].pad;
            latch_window($sformatf("vec%0d", i), int'(vecs[i].exp));
        end

        // Window at position 127: pad_out falls one clock after count reaches 127
        p1_mode = 1; p1_ax = 8'h00;
        latch_window("win127", 127);
        for (int i = 0; i < 200; i++) hpulse("win127", 127);

        // Position 255: count saturates, pad_out drops only at 255
        p1_mode = 5; paddle_0 = 8'h00;
        latch_window("win255", 255);
        for (int i = 0; i < 257; i++) hpulse("win255", 255);

        // Target changes and player toggles while counting do not reach pos_active
        p1_mode = 6; paddle_0 = 8'h40; p2_mode = 7;
        latch_window("frz", 8'h40);
        paddle_0 = 8'h90;
        repeat (3) tick();
        push_pos("frz paddle", 8'h40);
        @(negedge clk_sys); compare_all(); tick();
        player2 = 1;
        frame(0, 0, 0, 0);
        push_pos("frz player", 8'h40);
        @(negedge clk_sys); compare_all(); tick();
        player2 = 0;
        latch_window("frz next", 8'h90);

        player2 = 1; p2_mode = 6; paddle_1 = 8'h00;
        latch_window("p2 zero", 0);
        for (int i = 0; i < 10; i++) hpulse("p2 zero", 0);
        speed = 0;
        repeat (3) frame(1, 1, 0, 0);
        frame(0, 1, 0, 0);
        frame(0, 0, 0, 1);
        p2_mode = 0;
        latch_window("p2 dig", m_dpos2);
        player2 = 0; p1_mode = 0;
        latch_window("p1 ignored", m_dpos1);

        p1_mode = 6; paddle_0 = 8'hC8;
        latch_window("rst win", 8'hC8);
        for (int i = 0; i < 50; i++) hpulse("rst win", 200);
        reset_n = 0;
        #2;
        push_pos("async rst pos", 114);
        push_pad("async rst pad", 1'b0);
        compare_all();
        tick();
        reset_n = 1;
        m_dpos1 = 114; m_dpos2 = 114; m_cnt = 0;
        for (int i = 0; i < 120; i++) hpulse("post rst", 114);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
